// File: rtl/bitonic_pkg.sv
// rtl/bitonic_pkg.sv - shared FSM encoding and clog2 helper for the sorted-vector datapath
package bitonic_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sorted_vector_serializer.sv
// rtl/sorted_vector_serializer.sv - drains one sorted N-wide vector as a tagged element stream
module sorted_vector_serializer
   import bitonic_pkg::*;
#(
   parameter int N           = 16,
   parameter int log_N       = 4,
   parameter int INPUT_WIDTH = 4,
   parameter int ORDER       = 0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [0:INPUT_WIDTH*N-1]       in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [INPUT_WIDTH-1:0]         out,
   output logic [log_N-1:0]               out_idx,
   output logic                           out_last
);

   localparam logic [log_N-1:0] LAST_CNT = log_N'(N - 1);

   // Catch an inconsistent N / log_N pairing at elaboration time.
   if ((2 ** log_N) != N || clog2(N) != log_N) begin : g_bad_params
      $error("sorted_vector_serializer: N must equal 2**log_N");
   end

   state_t                      state_q, state_d;
   logic [log_N-1:0]            cnt_q, cnt_d;
   logic [0:INPUT_WIDTH*N-1]    buf_q, buf_d;
   logic                        out_acc;
   logic                        in_acc;

   // State, position counter and holding register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   // Output tagging, handshakes and next-state; in_ready reopens on the last
   // element's accept so the next vector follows without a bubble.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      out_valid = (state_q == DRAIN);
      out_last  = out_valid && (cnt_q == LAST_CNT);
      out_idx   = (ORDER != 0) ? (LAST_CNT - cnt_q) : cnt_q;
      out_acc   = out_valid && out_ready;
      in_ready  = (state_q == IDLE) || (out_acc && out_last);
      in_acc    = in_valid && in_ready;

      case (state_q)
         IDLE: begin
            if (in_acc) begin
               buf_d   = in;
               cnt_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_acc) begin
               if (!out_last) begin
                  cnt_d = cnt_q + log_N'(1);
               end else if (in_valid) begin
                  buf_d = in;
                  cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Element select: N:1 mux over the held vector, indexed by the emitted position.
   always_comb begin
      out = buf_q[int'(out_idx) * INPUT_WIDTH +: INPUT_WIDTH];
   end

endmodule

// File: doc/sorted_vector_serializer.md
# sorted_vector_serializer

Drains one wide, sorted vector (the registered output of the N-input bitonic merge network) as a stream of single elements, one per accepted handshake, with index and last-element tags. Sits directly downstream of the merge network in the packet-classification datapath. It converts the N-wide parallel result into the narrow stream consumed by the rule-priority and result logic. Valid/ready on both sides; back-to-back vectors are drained with no idle cycle.

## Interface
- N, 16, number of elements per vector; power of two, ≥2
- log_N, 4, clog2(N)
- INPUT_WIDTH, 4, width of one element
- ORDER, 0, 0: emit element 0 first (index ascending); 1: emit element N-1 first
- clk  input  1  clock, positive edge
- reset_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  `in` holds a vector to be drained
- in_ready  output  1  vector accepted on a cycle with in_valid && in_ready
- in  input  INPUT_WIDTH*N, [0:INPUT_WIDTH*N-1]  element k at bits [k*INPUT_WIDTH +: INPUT_WIDTH]
- out_valid  output  1  out/out_idx/out_last valid
- out_ready  input  1  element consumed on out_valid && out_ready
- out  output  INPUT_WIDTH  current element
- out_idx  output  log_N  position of current element within its vector (0..N-1)
- out_last  output  1  current element is the final one of its vector

## Operation
- Holding register `buf` (INPUT_WIDTH*N), counter `cnt` (log_N bits), FSM {IDLE, DRAIN}.
- IDLE: in_ready=1, out_valid=0. On in accept: buf<=in, cnt<=0, go to DRAIN.
- DRAIN: out_valid=1; out = buf element at out_idx; out_idx = cnt (ORDER=0) or N-1-cnt (ORDER=1); out_last = (cnt==N-1).
- On out accept with cnt<N-1: cnt<=cnt+1.
- On out accept with cnt==N-1: if in_valid, load buf<=in, cnt<=0, stay in DRAIN; else go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready, intentional for zero-bubble chaining.
- out_ready low: out, out_idx, out_last held stable; cnt and buf unchanged.
- in is sampled only on accept; changes to in while DRAIN and not accepting are ignored.
- Element content is not inspected; no comparison or reordering is done here.

## Timing
- Reset (async assert, sync release from the clk domain): state=IDLE, cnt=0, buf=0. Resulting outputs: out_valid=0, in_ready=1, out=0, out_idx=0 (ORDER=0) or N-1 (ORDER=1), out_last=0.
- Reset asserted mid-drain: the remaining elements are discarded; there is no partial output after release.
- Latency: vector accepted at edge t → first element valid after edge t, i.e. presented in cycle t+1.
- Throughput: one vector per N cycles with out_ready held high; no gap between the last element of vector k and the first of vector k+1.
- The merge network carries no valid. The integrating wrapper delays its own valid by log_N+1 cycles to form in_valid, and stalls the merge input while in_ready=0.

## Structure
- Shared header/package `bitonic_pkg`: FSM state encoding (IDLE=1'b0, DRAIN=1'b1) and a clog2 function used for log_N checks.
- Element select is an N:1 mux indexed by out_idx; implement it inline. No sub-module is needed.
- Elaboration check: 2**log_N == N.

## Test plan
All tests use N=4, INPUT_WIDTH=4.
- Reset: reset_n low with in_valid=1 → out_valid=0, in_ready=1, out=0; after release, nothing is emitted until an accept.
- Single vector, ORDER=0, in={1,3,7,9}, out_ready=1 → out 1,3,7,9 on cycles t+1..t+4; out_idx 0..3; out_last only with 9; out_valid falls at t+5.
- ORDER=1, same vector → out 9,7,3,1; out_idx 3,2,1,0; out_last with 1.
- Back-to-back: {1,3,7,9} then {2,4,6,8} held valid → in_ready pulses on the cycle 9 is accepted; 8 contiguous valid elements with no gap.
- Backpressure: out_ready toggles 1,0,0,1,… → each element held stable while stalled; sequence unchanged; in_ready=0 throughout the drain except the final accept.
- Reset mid-drain after 2 elements are accepted → out_valid=0 immediately on reset assert; after release, the next accepted vector starts at out_idx 0.
